cypher_uart_tx: RTL and testbench
=================================

Name: cypher_uart_tx

Overview:
Downstream consumer of the Encryptor's 8-bit `cypher` output stream. Each cycle with a nonzero `cypher` byte is captured into a small FIFO, then serialized on a single UART-style line (8N1, LSB first). This gets ciphertext off-chip without depending on simulator `$display`. It sits between the Encryptor and the top-level pin.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit (≥2)
- FIFO_DEPTH, 16, byte capacity of the capture FIFO (power of 2, ≥2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cypher_in  in  8  Encryptor output; nonzero = valid byte this cycle
- tx  out  1  serial line, idles high
- busy  out  1  high while FIFO non-empty or a frame is in flight
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset values:
  - tx=1, busy=0, fifo_count=0, overflow=0
  - FSM in IDLE
  - FIFO pointers cleared
- Reset behaviour:
  - Reset is synchronous and active-high on `rst`, sampled on the rising edge of `clk`.
  - Reset mid-frame aborts the frame: tx returns to 1 at the next edge.
  - All FIFO contents are discarded.
- Capture:
  - At each rising edge, cypher_in != 0 pushes one byte.
  - A zero byte is never pushed.
  - A constant nonzero value held for N cycles pushes N bytes.
- Full handling:
  - Fullness is judged on the pre-edge count.
  - If full and no pop in the same edge, the byte is dropped and overflow sets to 1 until rst.
  - If full and a pop occurs in the same edge, the push is accepted and count stays at FIFO_DEPTH.
- Simultaneous push and pop on non-full: count unchanged.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits LSB first, each CLKS_PER_BIT cycles, tracked by a bit index 0..7; then go to STOP (or PARITY if enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Latency: byte pushed at edge k → popped at edge k+1 → tx low from after edge k+1.
- Frame length: 10*CLKS_PER_BIT cycles (11* with parity).
- Registers:
  - tx is registered, with no combinational path from cypher_in.
  - The baud counter is ceil(log2(CLKS_PER_BIT)) bits wide and reloads to 0 on every bit boundary.
- FIFO pointers wrap modulo FIFO_DEPTH; count saturates logically at FIFO_DEPTH (never exceeds it).
- busy = (state != IDLE) | (fifo_count != 0).

Optional Feature:
- Macro: CYPHER_TX_PARITY_EN
- Defined: PARITY state inserted between DATA and STOP. It transmits even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame is 11 bits.
- Undefined: no PARITY state, 8N1 frame of 10 bits.
- Capture and FIFO behaviour are identical in both builds.

Decomposition:
- Package cypher_pkg:
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP}, present even when parity is unused
  - UART_DATA_BITS=8
  - localparam helpers for counter widths
- Sub-module byte_fifo (params DEPTH, WIDTH=8):
  - push/pop/full/empty/count
  - the same-edge push-when-full-with-pop rule lives here
- FSM, shifter and baud counter live in cypher_uart_tx.

Test Plan:
- Single byte, CLKS_PER_BIT=4, one cycle of cypher_in=0x5A (else 0) → tx frame, 4 cycles per bit:
  - start bit 0
  - data bits 0,1,0,1,1,0,1,0
  - stop bit 1
  - tx low exactly 2 edges after the push cycle
  - busy high 41 cycles
- Zero filtering: cypher_in=0x00 for 100 cycles → tx stays 1, fifo_count=0, busy=0.
- Burst of 0x41,0x43,0x54 on 3 consecutive cycles, CLKS_PER_BIT=4 → three back-to-back frames, 120 cycles with no idle-high gap between stop and next start; fifo_count peaks at 2.
- Overflow, FIFO_DEPTH=4, six distinct nonzero bytes b1..b6 on consecutive cycles:
  - fifo_count reaches 4
  - b6 dropped, overflow=1 from the 6th edge
  - tx emits exactly b1..b5 in order
- Reset mid-DATA: rst high 1 cycle during bit 3 of a frame, with 2 bytes queued → tx=1, fifo_count=0, busy=0, overflow=0 after the edge; no further frames.
- CYPHER_TX_PARITY_EN defined, byte 0x07 → 11-bit frame with parity bit 1; byte 0x03 → parity bit 0.

Source files
------------

// File: rtl/cypher_pkg.sv
// Shared types and width helpers for the ciphertext UART transmitter.
// Pure declarations: no latency, no flow control.
package cypher_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int BIT_IDX_W      = $clog2(UART_DATA_BITS);

    // Baud counter width: ceil(log2(clks)), never narrower than one bit.
    function automatic int baud_width(input int clks);
        return (clks < 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Capture FIFO for ciphertext bytes; registered pointers, head readable combinationally.
// Push while full is dropped unless a pop happens on the same edge, which frees the slot.
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cypher_uart_tx.sv
// Captures nonzero cypher bytes and sends them 8N1 LSB first; push to start bit is two edges.
// No backpressure upstream: bytes arriving on a full FIFO are dropped (sticky overflow). Macro CYPHER_TX_PARITY_EN adds an even parity bit.
module cypher_uart_tx
    import cypher_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  cypher_in,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int BAUD_W = baud_width(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] BIT_LAST  = BIT_IDX_W'(UART_DATA_BITS - 1);

    tx_state_t                 state_q, state_d;
    logic [BAUD_W-1:0]         baud_q, baud_d;
    logic [BIT_IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      tx_q, tx_d;
    logic                      bit_end;
    logic                      push_req;
    logic                      pop;
    logic [7:0]                head_dat;
    logic                      fifo_full;
    logic                      fifo_empty;

    assign push_req = |cypher_in;
    assign bit_end  = (baud_q == BAUD_LAST);

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_req),
        .push_dat (cypher_in),
        .pop      (pop),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        baud_d    = bit_end ? '0 : baud_q + 1'b1;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        pop       = 1'b0;
        tx_d      = 1'b1;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    data_d  = head_dat;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == BIT_LAST) begin
`ifdef CYPHER_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
`ifdef CYPHER_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Chain straight into the next start bit when more bytes are waiting.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        data_d  = head_dat;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[bit_idx_d];
`ifdef CYPHER_TX_PARITY_EN
            PARITY:  tx_d = ^data_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            tx_q      <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            tx_q      <= tx_d;
            if (push_req && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE) | (fifo_count != '0);

endmodule

// File: tb/tb_cypher_uart_tx.sv
// Directed and random stimulus for cypher_uart_tx, checked every cycle against a frame-level model.
module tb_cypher_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef CYPHER_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [7:0]               cypher_in = 8'h00;
    logic                     tx;
    logic                     busy;
    logic                     overflow;
    logic [$clog2(DEPTH):0]   fifo_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: queue of waiting bytes plus the frame currently on the line.
    logic [7:0] q[$];
    logic [7:0] cur = 8'h00;
    int         start = 0;
    bit         active = 1'b0;
    bit         m_ovf = 1'b0;

    cypher_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cypher_in  (cypher_in),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [7:0] b, input logic r);
        int  pre;
        bit  do_pop;
        if (r) begin
            q.delete();
            active = 1'b0;
            m_ovf  = 1'b0;
            return;
        end
        pre    = q.size();
        do_pop = (!active || cyc >= start + FRAME) && (pre > 0);
        if (do_pop) begin
            cur    = q.pop_front();
            start  = cyc;
            active = 1'b1;
        end else if (active && cyc >= start + FRAME) begin
            active = 1'b0;
        end
        if (b != 8'h00) begin
            if (pre < DEPTH || do_pop) q.push_back(b);
            else m_ovf = 1'b1;
        end
    endtask

    function automatic logic exp_tx();
        int k;
        if (!active) return 1'b1;
        k = (cyc - start) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return cur[k-1];
`ifdef CYPHER_TX_PARITY_EN
        if (k == 9) return ^cur;
`endif
        return 1'b1;
    endfunction

    task automatic step(input logic [7:0] b, input logic r);
        @(negedge clk);
        cypher_in = b;
        rst       = r;
        @(posedge clk);
        cyc++;
        model_edge(b, r);
        #1;
        chk("tx",         {7'd0, tx},       {7'd0, exp_tx()});
        chk("busy",       {7'd0, busy},     {7'd0, (active || q.size() != 0)});
        chk("fifo_count", 8'(fifo_count),   8'(q.size()));
        chk("overflow",   {7'd0, overflow}, {7'd0, m_ovf});
    endtask

    initial begin
        int         lat;
        int         nb;
        int         peak;
        logic [7:0] ob[6];
        logic [7:0] b;
        int         dense;

        // Reset
        for (int i = 0; i < 3; i++) step(8'h00, 1'b1);
        chk("reset_tx", {7'd0, tx}, 8'h01);
        chk("reset_count", 8'(fifo_count), 8'h00);

        // Zero filtering
        for (int i = 0; i < 100; i++) step(8'h00, 1'b0);
        chk("zero_busy", {7'd0, busy}, 8'h00);

        // Single byte: latency and busy duration
        step(8'h5A, 1'b0);
        lat = 1;
        nb  = busy ? 1 : 0;
        while (tx !== 1'b0 && lat < 20) begin
            step(8'h00, 1'b0);
            lat++;
            if (busy) nb++;
        end
        while (busy === 1'b1 && nb < 200) begin
            step(8'h00, 1'b0);
            if (busy) nb++;
        end
        chk("single_latency", 8'(lat), 8'd2);
        chk("single_busy_cycles", 8'(nb), 8'(FRAME + 1));
        for (int i = 0; i < 5; i++) step(8'h00, 1'b0);

        // Burst of three, back-to-back frames
        peak = 0;
        step(8'h41, 1'b0); if (fifo_count > peak) peak = fifo_count;
        step(8'h43, 1'b0); if (fifo_count > peak) peak = fifo_count;
        step(8'h54, 1'b0); if (fifo_count > peak) peak = fifo_count;
        for (int i = 0; i < 3 * FRAME + 10; i++) begin
            step(8'h00, 1'b0);
            if (fifo_count > peak) peak = fifo_count;
        end
        chk("burst_peak", 8'(peak), 8'd2);

        // Overflow: sixth byte dropped
        ob[0] = 8'h11; ob[1] = 8'h22; ob[2] = 8'h33;
        ob[3] = 8'h44; ob[4] = 8'h55; ob[5] = 8'h66;
        peak = 0;
        for (int i = 0; i < 6; i++) begin
            step(ob[i], 1'b0);
            if (fifo_count > peak) peak = fifo_count;
            if (i == 4) chk("ovf_before", {7'd0, overflow}, 8'h00);
        end
        chk("ovf_set", {7'd0, overflow}, 8'h01);
        chk("ovf_peak", 8'(peak), 8'd4);
        for (int i = 0; i < 5 * FRAME + 10; i++) step(8'h00, 1'b0);
        chk("ovf_sticky", {7'd0, overflow}, 8'h01);

        // Reset during data bit 3 with two bytes queued
        step(8'hA1, 1'b0);
        step(8'hB2, 1'b0);
        step(8'hC3, 1'b0);
        for (int i = 0; i < 200; i++) begin
            if (active && (cyc - start) / CPB == 4) break;
            step(8'h00, 1'b0);
        end
        chk("pre_rst_queued", 8'(fifo_count), 8'd2);
        step(8'h00, 1'b1);
        chk("rst_tx", {7'd0, tx}, 8'h01);
        chk("rst_count", 8'(fifo_count), 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_ovf", {7'd0, overflow}, 8'h00);
        for (int i = 0; i < 60; i++) step(8'h00, 1'b0);

        // Parity / stop bit slot for 0x07 and 0x03
        for (int t = 0; t < 2; t++) begin
            b = (t == 0) ? 8'h07 : 8'h03;
            step(b, 1'b0);
            lat = 0;
            while (tx !== 1'b0 && lat < 10) begin
                step(8'h00, 1'b0);
                lat++;
            end
            for (int i = 0; i < 9 * CPB + 1; i++) step(8'h00, 1'b0);
`ifdef CYPHER_TX_PARITY_EN
            chk("parity_bit", {7'd0, tx}, (t == 0) ? 8'h01 : 8'h00);
`else
            chk("stop_bit", {7'd0, tx}, 8'h01);
`endif
            for (int i = 0; i < FRAME; i++) step(8'h00, 1'b0);
        end

        // Random traffic with varying density and rare resets
        dense = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) dense = $urandom_range(0, 3);
            if ($urandom_range(0, dense == 3 ? 1 : 20) == 0) b = 8'($urandom_range(1, 255));
            else b = 8'h00;
            step(b, ($urandom_range(0, 999) == 0));
        end
        for (int i = 0; i < 6 * FRAME; i++) step(8'h00, 1'b0);
        chk("drain_idle", {7'd0, busy}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
